// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, LSB first, one-cycle byte strobe and frame-error strobe.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop (adds o_Parity_Err).
module uart_rx #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
`ifdef UART_RX_PARITY_EN
  output logic       o_Parity_Err,
`endif
  output logic       o_Frame_Err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY  = 3'd3;
`endif
  localparam logic [2:0] STOP    = 3'd4;
  localparam logic [2:0] CLEANUP = 3'd5;

  logic [2:0]    r_State;
  logic [CW-1:0] r_Clock_Count;
  logic [2:0]    r_Bit_Index;
  logic [7:0]    r_Byte;
  logic          sync1_r;
  logic          rx_s;
  logic          r_Prev;
`ifdef UART_RX_PARITY_EN
  logic          r_Parity_Bit;

  function automatic logic parity_even_ok(input logic [7:0] data, input logic par);
    return ~((^data) ^ par);
  endfunction
`endif

  // Two-flop synchronizer plus one-cycle history for start-edge detection
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
      r_Prev  <= 1'b1;
    end else begin
      sync1_r <= i_RX_Serial;
      rx_s    <= sync1_r;
      r_Prev  <= rx_s;
    end
  end

  // Frame FSM: strobes default low every cycle so each pulse lasts exactly one clock
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_State       <= IDLE;
      r_Clock_Count <= '0;
      r_Bit_Index   <= 3'd0;
      r_Byte        <= 8'h00;
      o_RX_DV       <= 1'b0;
      o_RX_Byte     <= 8'h00;
      o_RX_Active   <= 1'b0;
      o_Frame_Err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_Parity_Bit  <= 1'b0;
      o_Parity_Err  <= 1'b0;
`endif
    end else begin
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_Parity_Err <= 1'b0;
`endif
      case (r_State)
        IDLE: begin
          r_Clock_Count <= '0;
          r_Bit_Index   <= 3'd0;
          // A line already low (break) never starts a frame; only a fresh 1->0 edge does
          if (r_Prev && !rx_s) begin
            r_State     <= START;
            o_RX_Active <= 1'b1;
          end else begin
            r_State     <= IDLE;
            o_RX_Active <= 1'b0;
          end
        end

        START: begin
          if (r_Clock_Count == MID_CNT) begin
            r_Clock_Count <= '0;
            r_Bit_Index   <= 3'd0;
            if (!rx_s) begin
              r_State <= DATA;
            end else begin
              r_State     <= IDLE;
              o_RX_Active <= 1'b0;
            end
          end else begin
            r_Clock_Count <= r_Clock_Count + 1'b1;
          end
        end

        DATA: begin
          if (r_Clock_Count == LAST_CNT) begin
            r_Clock_Count       <= '0;
            r_Byte[r_Bit_Index] <= rx_s;
            if (r_Bit_Index == 3'd7) begin
              r_Bit_Index <= 3'd0;
`ifdef UART_RX_PARITY_EN
              r_State     <= PARITY;
`else
              r_State     <= STOP;
`endif
            end else begin
              r_Bit_Index <= r_Bit_Index + 3'd1;
            end
          end else begin
            r_Clock_Count <= r_Clock_Count + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_Clock_Count == LAST_CNT) begin
            r_Clock_Count <= '0;
            r_Parity_Bit  <= rx_s;
            r_State       <= STOP;
          end else begin
            r_Clock_Count <= r_Clock_Count + 1'b1;
          end
        end
`endif

        STOP: begin
          if (r_Clock_Count == LAST_CNT) begin
            r_Clock_Count <= '0;
            r_State       <= CLEANUP;
            if (rx_s) begin
              o_RX_Byte <= r_Byte;
              o_RX_DV   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              o_Parity_Err <= ~parity_even_ok(r_Byte, r_Parity_Bit);
`endif
            end else begin
              o_Frame_Err <= 1'b1;
            end
          end else begin
            r_Clock_Count <= r_Clock_Count + 1'b1;
          end
        end

        CLEANUP: begin
          r_Clock_Count <= '0;
          r_Bit_Index   <= 3'd0;
          o_RX_Active   <= 1'b0;
          r_State       <= IDLE;
        end

        default: begin
          r_Clock_Count <= '0;
          r_Bit_Index   <= 3'd0;
          o_RX_Active   <= 1'b0;
          r_State       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity by default.
- Recovers bytes from the asynchronous serial line and presents each as a one-cycle valid strobe with the byte.
- Receive-side partner of the team's UART transmitter; shares the same CLKS_PER_BIT convention so both ends run at the same baud from the same clock.

Parameters:
- CLKS_PER_BIT, 2604, clock cycles per bit (i_Clock frequency / baud rate); minimum 4.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_RX_Serial  in  1  asynchronous serial line, idle high
- o_RX_DV  out  1  one-cycle strobe: o_RX_Byte valid
- o_RX_Byte  out  8  last good received byte; held until next good byte
- o_RX_Active  out  1  high while a frame is being received
- o_Frame_Err  out  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Reset: i_Rst high at a rising edge forces state IDLE and drives:
  - o_RX_DV=0, o_Frame_Err=0, o_RX_Active=0, o_RX_Byte=8'h00.
  - Both synchronizer flops and the previous-sample flop to 1.
  - Counters to 0.
  - Reset mid-frame discards the partial byte with no strobe.
- Input sync: i_RX_Serial passes through 2 flops. All decisions use the 2nd flop (rx_s). r_Prev holds rx_s delayed one cycle.
- Counter: r_Clock_Count, width $clog2(CLKS_PER_BIT)+1. Bit index: 3 bits.
- IDLE:
  - Outputs low; counters 0.
  - Falling edge (r_Prev=1, rx_s=0) -> START, o_RX_Active<=1.
  - A line held low, e.g. a break or a post-error low, never starts a frame; a fresh 1->0 edge is required.
- START: count to (CLKS_PER_BIT-1)/2 (mid start bit), then sample rx_s.
  - rx_s=0 -> DATA, count<=0, index<=0.
  - rx_s=1 -> glitch: IDLE, o_RX_Active<=0, no strobe.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into r_Byte[index] and clear the count.
  - index<7 -> index+1; index=7 -> STOP.
- STOP: count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s=1 -> o_RX_Byte<=r_Byte, o_RX_DV<=1 for exactly one cycle.
  - rx_s=0 -> o_Frame_Err<=1 for one cycle; o_RX_Byte unchanged; no o_RX_DV.
  - Either outcome -> CLEANUP.
- CLEANUP (1 cycle): clear strobes, o_RX_Active<=0, -> IDLE.
- Latency: the strobe asserts the cycle after the mid-stop sample, about 9.5 bit times plus 3 cycles after the line falling edge.
- Back-to-back frames: the stop sample lands mid stop bit, so the receiver is back in IDLE well before the next start edge. Zero idle gap between frames is supported.
- Illegal state encoding -> IDLE.
- o_RX_DV and o_Frame_Err are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - State PARITY is inserted between DATA and STOP; it counts CLKS_PER_BIT-1 and then samples the parity bit.
  - Even parity is required: XOR of the 8 data bits and the parity bit = 0.
  - Adds output o_Parity_Err (1 bit, reset 0). It pulses in the same cycle as o_RX_DV when the stop bit is good but parity mismatches. The byte is still delivered.
  - If the stop bit is bad, only o_Frame_Err pulses.
- Undefined: no PARITY state and no o_Parity_Err port; frame is 10 bits.

Test Plan (CLKS_PER_BIT=16):
- Send 8'hA5 with a valid stop -> exactly one o_RX_DV pulse, o_RX_Byte=8'hA5, o_Frame_Err=0, o_RX_Active high for the frame only.
- Pulse the line low for 4 cycles, then return high -> no strobe, o_RX_Active drops after the mid-start check, next frame 8'h3C received correctly.
- Send 8'h3C with stop bit 0 after a prior good byte 8'h11 -> o_Frame_Err one-cycle pulse, no o_RX_DV, o_RX_Byte stays 8'h11. Line held low 40 cycles then released -> no spurious frame.
- Send 8'h00 then 8'hFF with zero idle gap -> two o_RX_DV pulses carrying 8'h00 and 8'hFF, in order.
- Assert i_Rst for 1 cycle during data bit 4 of 8'h96 -> all outputs reset, no strobe. Following frame 8'h55 -> o_RX_Byte=8'h55.
- With UART_RX_PARITY_EN, send 8'h07:
  - Parity bit 1 -> o_RX_DV with o_Parity_Err=0.
  - Parity bit 0 -> o_RX_DV and o_Parity_Err both pulse, o_RX_Byte=8'h07.
